amber48_uart_tx: RTL and testbench

- Serial UART transmitter that consumes the byte stream from the data-memory MMIO UART register (uart_tx_valid/data/ready) and drives the board TX pin.
- Small FIFO absorbs the one-cycle valid-after-ready skew of the registered store path.
- 8N1 framing, LSB first, fixed integer baud divider.

---
 rtl/amber48_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_amber48_uart_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amber48_uart_tx.sv
// amber48_uart_tx: 8N1 serial transmitter fed from the dmem MMIO UART register.
// A small byte FIFO absorbs the registered store path's valid-after-ready skew;
// the frame FSM pops one byte per frame and shifts it out LSB first.
module amber48_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        tx_valid_i,
    input  logic [7:0]                  tx_data_i,
    output logic                        tx_ready_o,
    output logic                        txd_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o,
    input  logic                        clr_overflow_i
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W:0]    READY_LIM = (LVL_W + 1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  count_q;
    logic              overflow_q;

    logic              pop;
    logic              push_ok;
    logic              drop;
    logic              non_empty;
    logic [LVL_W:0]    ready_sum;

    assign non_empty = (count_q != '0);

    // A byte arriving while full still fits if the FSM frees the head slot this cycle.
    assign push_ok = tx_valid_i && ((count_q < FULL_LVL) || pop);
    assign drop    = tx_valid_i && !push_ok;

    // Ready leaves one slot spare for the store already in flight behind it.
    assign ready_sum  = {1'b0, count_q} + {{LVL_W{1'b0}}, tx_valid_i};
    assign tx_ready_o = (ready_sum < READY_LIM);

    assign txd_o        = txd_q;
    assign busy_o       = (state_q != IDLE) || non_empty;
    assign fifo_level_o = count_q;
    assign overflow_o   = overflow_q;

    // Frame sequencing: next state, baud/bit counters, shifter, pop and next line level.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (non_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (non_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is derived from the next state so txd_q is a clean flop output.
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // FSM, shifter and line register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a drop wins over a clear).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; the pointers and count alone define valid contents.
        if (push_ok) mem[wr_ptr_q] <= tx_data_i;
    end

endmodule

// File: tb/tb_amber48_uart_tx.sv
// Self-checking bench for amber48_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Expected bytes go into a scoreboard queue when driven; a line monitor
// decodes every frame sample by sample and compares against the queue head.
module tb_amber48_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       tx_valid_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o;
    logic       txd_o;
    logic       busy_o;
    logic [2:0] fifo_level_o;
    logic       overflow_o;
    logic       clr_overflow_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    amber48_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tx_valid_i     (tx_valid_i),
        .tx_data_i      (tx_data_i),
        .tx_ready_o     (tx_ready_o),
        .txd_o          (txd_o),
        .busy_o         (busy_o),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o),
        .clr_overflow_i (clr_overflow_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic check_start(input string tag, input int exp);
        logic [31:0] s;
        s = (starts.size() != 0) ? 32'(starts.pop_front()) : 32'hFFFF_FFFF;
        check(tag, s, 32'(exp));
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        check(tag, busy_o, 1'b0);
    endtask

    // Line monitor: decodes each frame at every negedge and compares to the scoreboard.
    initial begin : monitor
        logic [7:0] cur;
        logic       e;
        forever begin
            @(negedge clk_i);
            if (rst_ni === 1'b1 && txd_o === 1'b0) begin
                starts.push_back(cyc);
                check("frame_expected", 32'(exp_q.size() != 0), 1);
                cur = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                for (int s = 0; s < 10 * CPB; s++) begin
                    if (s > 0) @(negedge clk_i);
                    if (rst_ni !== 1'b1) break;
                    if (s < CPB)            e = 1'b0;
                    else if (s < 9 * CPB)   e = cur[(s - CPB) / CPB];
                    else                    e = 1'b1;
                    check($sformatf("txd_byte%02h_s%0d", cur, s), txd_o, e);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin : stim
        int         t;
        int         issued;
        int         data_idx;
        int         blk_sum;
        logic       pend;
        logic       next_pend;
        logic       seen_block;
        logic [7:0] skew_bytes [6];
        logic [7:0] ov_bytes   [5];

        skew_bytes = '{8'hC1, 8'h7E, 8'h90, 8'h2B, 8'hD4, 8'h66};
        ov_bytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst_ni         = 1'b0;
        tx_valid_i     = 1'b0;
        tx_data_i      = 8'h00;
        clr_overflow_i = 1'b0;
        repeat (3) tick();

        // Reset values.
        check("rst_txd",      txd_o,        1'b1);
        check("rst_overflow", overflow_o,   1'b0);
        check("rst_level",    fifo_level_o, 3'd0);
        check("rst_busy",     busy_o,       1'b0);
        check("rst_ready",    tx_ready_o,   1'b1);
        rst_ni = 1'b1;

        // Single byte 0xA5 from idle.
        wait_cyc(10);
        t = cyc;
        exp_q.push_back(8'hA5);
        tx_valid_i = 1'b1;
        tx_data_i  = 8'hA5;
        tick();
        tx_valid_i = 1'b0;
        tx_data_i  = 8'hFF;
        check("t1_level_after_push", fifo_level_o, 3'd1);
        tick();
        check("t1_level_at_start", fifo_level_o, 3'd0);
        wait_cyc(t + 41);
        check("t1_busy_last_stop", busy_o, 1'b1);
        tick();
        check("t1_busy_done", busy_o, 1'b0);
        check("t1_txd_idle", txd_o, 1'b1);
        check_start("t1_start_cycle", t + 2);
        check("t1_sb_empty", 32'(exp_q.size()), 0);

        // Back-to-back frames.
        repeat (3) tick();
        t = cyc;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h55;
        tick();
        check("t2_level_a", fifo_level_o, 3'd1);
        tx_data_i = 8'h0F;
        tick();
        tx_valid_i = 1'b0;
        check("t2_level_b", fifo_level_o, 3'd1);
        wait_cyc(t + 42);
        check("t2_level_c", fifo_level_o, 3'd0);
        tick();
        check_start("t2_start_first", t + 2);
        check_start("t2_start_second", t + 42);
        wait_cyc(t + 82);
        check("t2_busy_done", busy_o, 1'b0);
        check("t2_sb_empty", 32'(exp_q.size()), 0);

        // Ready-skew producer with the transmitter mid-frame.
        repeat (3) tick();
        t = cyc;
        exp_q.push_back(8'h3C);
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h3C;
        tick();
        tx_valid_i = 1'b0;
        wait_cyc(t + 5);
        pend       = 1'b0;
        issued     = 0;
        data_idx   = 0;
        blk_sum    = -1;
        seen_block = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tx_valid_i = pend;
            if (pend) begin
                tx_data_i = skew_bytes[data_idx];
                exp_q.push_back(skew_bytes[data_idx]);
                data_idx++;
            end
            #1;
            next_pend = 1'b0;
            if (tx_ready_o === 1'b1 && issued < 6) begin
                next_pend = 1'b1;
                issued++;
            end
            if (tx_ready_o !== 1'b1 && !seen_block) begin
                seen_block = 1'b1;
                blk_sum    = int'(fifo_level_o) + int'(tx_valid_i);
            end
            pend = next_pend;
            tick();
        end
        tx_valid_i = 1'b0;
        check("t3_issued", 32'(issued), 3);
        check("t3_block_sum", 32'(blk_sum), 3);
        check("t3_level", fifo_level_o, 3'd3);
        check("t3_overflow", overflow_o, 1'b0);
        wait_idle("t3_drain", 300);
        check("t3_sb_empty", 32'(exp_q.size()), 0);
        starts.delete();

        // Forced overflow, clear, clear-vs-drop, then push into full during pop.
        repeat (3) tick();
        t = cyc;
        exp_q.push_back(8'h81);
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h81;
        tick();
        tx_valid_i = 1'b0;
        wait_cyc(t + 5);
        for (int i = 0; i < 5; i++) begin
            tx_valid_i = 1'b1;
            tx_data_i  = ov_bytes[i];
            if (i < 4) exp_q.push_back(ov_bytes[i]);
            tick();
        end
        tx_valid_i = 1'b0;
        check("t4_level_sat", fifo_level_o, 3'd4);
        check("t4_overflow_set", overflow_o, 1'b1);
        clr_overflow_i = 1'b1;
        tick();
        clr_overflow_i = 1'b0;
        check("t4_overflow_clr", overflow_o, 1'b0);
        clr_overflow_i = 1'b1;
        tx_valid_i     = 1'b1;
        tx_data_i      = 8'hEE;
        tick();
        clr_overflow_i = 1'b0;
        tx_valid_i     = 1'b0;
        check("t4_overflow_set_wins", overflow_o, 1'b1);
        check("t4_level_still_full", fifo_level_o, 3'd4);
        clr_overflow_i = 1'b1;
        tick();
        clr_overflow_i = 1'b0;
        check("t4_overflow_clr2", overflow_o, 1'b0);
        wait_cyc(t + 41);
        exp_q.push_back(8'h4D);
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h4D;
        tick();
        tx_valid_i = 1'b0;
        check("t5_level_full_pop", fifo_level_o, 3'd4);
        check("t5_no_overflow", overflow_o, 1'b0);
        tick();
        check_start("t5_start_e", t + 2);
        check_start("t5_start_next", t + 42);
        wait_idle("t5_drain", 400);
        check("t5_sb_empty", 32'(exp_q.size()), 0);
        starts.delete();

        // Reset during DATA bit 3 with two bytes queued.
        repeat (3) tick();
        t = cyc;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        tx_valid_i = 1'b1;
        tx_data_i  = 8'hF0;
        tick();
        tx_data_i = 8'h12;
        tick();
        tx_data_i = 8'h34;
        tick();
        tx_valid_i = 1'b0;
        check("t6_level_queued", fifo_level_o, 3'd2);
        wait_cyc(t + 19);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_txd_async", txd_o, 1'b1);
        check("t6_level_reset", fifo_level_o, 3'd0);
        check("t6_busy_reset", busy_o, 1'b0);
        exp_q.delete();
        tick();
        tick();
        starts.delete();
        rst_ni = 1'b1;
        repeat (100) tick();
        check("t6_no_frames", 32'(starts.size()), 0);
        check("t6_txd_idle", txd_o, 1'b1);
        check("t6_busy_idle", busy_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
